memory_be_pipe: RTL and testbench

Parametrised single-port synchronous memory with per-byte write enables, a configurable read-latency pipeline with a read-valid strobe, hardware clear-on-reset, and out-of-range address detection. It is the next-generation storage block for the memory verification environment: the DUT for the layered bench and golden-file flows where arbitrary width, depth and latency are required.

---
 rtl/memory_be_pipe.sv | 145 ++++++++++++++
 tb/tb_memory_be_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_be_pipe.sv
// Single-port byte-enable memory with hardware clear, read-latency pipeline and range check.
// Optional per-byte even parity is enabled with `define MEM_PARITY_EN.
module memory_be_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   be,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      rvalid,
    output logic                      busy,
    output logic                      err,
    output logic                      perr
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic                    in_range, wr_acc, rd_acc, perr_rd;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rdata_p0;
    logic                    vld_p0, err_p0, perr_p0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_cnt == LAST)
            state_nxt = READY;
    end

    assign busy     = (state == CLEAR);
    assign in_range = ({1'b0, addr} < DEPTH_W);
    assign wr_acc   = !busy && wr_en && in_range;
    // A simultaneous write wins; the read is dropped entirely.
    assign rd_acc   = !busy && rd_en && !wr_en;

    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_cnt] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++)
                if (be[i])
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

`ifdef MEM_PARITY_EN
    function automatic logic [NB-1:0] byte_parity(input logic [DATA_WIDTH-1:0] d);
        byte_parity = '0;
        for (int i = 0; i < NB; i++)
            byte_parity[i] = ^d[8*i +: 8];
    endfunction

    logic [NB-1:0] pmem [DEPTH];
    logic [NB-1:0] wpar;

    assign wpar = byte_parity(wdata);

    always_ff @(posedge clk) begin
        if (busy) begin
            pmem[clr_cnt] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++)
                if (be[i])
                    pmem[addr][i] <= wpar[i];
        end
    end

    assign perr_rd = |(byte_parity(mem[addr]) ^ pmem[addr]);
`else
    assign perr_rd = 1'b0;
`endif

    // Stage p0: array sampled at the accepting edge (after any prior-cycle write)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_p0 <= '0;
            vld_p0   <= 1'b0;
            err_p0   <= 1'b0;
            perr_p0  <= 1'b0;
        end else begin
            vld_p0  <= rd_acc;
            err_p0  <= rd_acc && !in_range;
            perr_p0 <= rd_acc && in_range && perr_rd;
            if (rd_acc)
                rdata_p0 <= in_range ? mem[addr] : '0;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] rdata_p1;
            logic                  vld_p1, err_p1, perr_p1;

            // Stage p1: extra output register, data only advances with a valid read
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_p1 <= '0;
                    vld_p1   <= 1'b0;
                    err_p1   <= 1'b0;
                    perr_p1  <= 1'b0;
                end else begin
                    vld_p1  <= vld_p0;
                    err_p1  <= err_p0;
                    perr_p1 <= perr_p0;
                    if (vld_p0)
                        rdata_p1 <= rdata_p0;
                end
            end

            assign rdata  = rdata_p1;
            assign rvalid = vld_p1;
            assign err    = err_p1;
            assign perr   = perr_p1;
        end else begin : g_lat1
            assign rdata  = rdata_p0;
            assign rvalid = vld_p0;
            assign err    = err_p0;
            assign perr   = perr_p0;
        end
    endgenerate

endmodule

// File: tb/tb_memory_be_pipe.sv
// Directed bench for memory_be_pipe: latency-1 and latency-2 instances share stimulus.
module tb_memory_be_pipe;
    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int DEP = 1000;
    localparam int NB  = 4;
    localparam int NV  = 23;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [NB-1:0] be = '0;

    logic [DW-1:0] rdata0, rdata1;
    logic          rvalid0, rvalid1, busy0, busy1, err0, err1, perr0, perr1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    memory_be_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .RD_LATENCY(1)) u0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .be(be), .rdata(rdata0), .rvalid(rvalid0), .busy(busy0),
        .err(err0), .perr(perr0));

    memory_be_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .RD_LATENCY(2)) u1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .be(be), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1),
        .err(err1), .perr(perr1));

    typedef struct {
        logic          wr;
        logic          rd;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [NB-1:0] b;
        logic [DW-1:0] xd;
        logic          xv;
        logic          xe;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic w, input logic r, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [NB-1:0] b,
                                input logic [DW-1:0] xd, input logic xv, input logic xe);
        vec_t v;
        v.wr = w; v.rd = r; v.a = a; v.d = d; v.b = b; v.xd = xd; v.xv = xv; v.xe = xe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [NB-1:0] b);
        wr_en = w; rd_en = r; addr = a; wdata = d; be = b;
    endtask

    task automatic chk_port(input string tag, input logic [DW-1:0] rd, input logic v,
                            input logic e, input logic p, input vec_t x,
                            inout logic [DW-1:0] last);
        if (x.xv) last = x.xd;
        chk({tag, " rvalid"}, {31'd0, v}, {31'd0, x.xv});
        chk({tag, " rdata"}, rd, last);
        chk({tag, " err"}, {31'd0, e}, {31'd0, x.xe});
        chk({tag, " perr"}, {31'd0, p}, 32'd0);
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (busy0 && n < 3000);
        chk({tag, " busy cycles"}, n, DEP);
        chk({tag, " busy1 low"}, {31'd0, busy1}, 32'd0);
    endtask

    logic [DW-1:0] last0, last1;

    initial begin
        vecs[0]  = mk(1'b0, 1'b1, 10'd999,  32'h0,        4'h0, 32'h0,        1'b1, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 10'd5,    32'hAABBCCDD, 4'hF, 32'h0,        1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 10'd5,    32'h11223344, 4'h5, 32'h0,        1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 10'd5,    32'h0,        4'h0, 32'hAA22CC44, 1'b1, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 10'd1000, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 10'd1000, 32'h0,        4'h0, 32'h0,        1'b1, 1'b1);
        vecs[6]  = mk(1'b0, 1'b1, 10'd999,  32'h0,        4'h0, 32'h0,        1'b1, 1'b0);
        vecs[7]  = mk(1'b1, 1'b1, 10'd7,    32'h000000FF, 4'hF, 32'h0,        1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 1'b1, 10'd7,    32'h0,        4'h0, 32'h000000FF, 1'b1, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 10'd1,    32'h11111111, 4'hF, 32'h0,        1'b0, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 10'd2,    32'h22222222, 4'hF, 32'h0,        1'b0, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 10'd3,    32'h33333333, 4'hF, 32'h0,        1'b0, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, 10'd1,    32'h0,        4'h0, 32'h11111111, 1'b1, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 10'd2,    32'h0,        4'h0, 32'h22222222, 1'b1, 1'b0);
        vecs[14] = mk(1'b0, 1'b1, 10'd3,    32'h0,        4'h0, 32'h33333333, 1'b1, 1'b0);
        vecs[15] = mk(1'b1, 1'b0, 10'd4,    32'hDEADBEEF, 4'h0, 32'h0,        1'b0, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, 10'd4,    32'h0,        4'h0, 32'h0,        1'b1, 1'b0);
        vecs[17] = mk(1'b0, 1'b1, 10'd1023, 32'h0,        4'h0, 32'h0,        1'b1, 1'b1);
        vecs[18] = mk(1'b1, 1'b0, 10'd6,    32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 1'b0);
        vecs[19] = mk(1'b0, 1'b1, 10'd6,    32'h0,        4'h0, 32'hCAFEF00D, 1'b1, 1'b0);
        vecs[20] = mk(1'b0, 1'b0, 10'd6,    32'h0,        4'h0, 32'h0,        1'b0, 1'b0);
        vecs[21] = mk(1'b1, 1'b0, 10'd8,    32'h5A5A5A5A, 4'hA, 32'h0,        1'b0, 1'b0);
        vecs[22] = mk(1'b0, 1'b1, 10'd8,    32'h0,        4'h0, 32'h5A005A00, 1'b1, 1'b0);

        // Reset values
        #2 reset = 1'b1;
        #1;
        chk("rst rdata0", rdata0, 32'd0);
        chk("rst rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst err0", {31'd0, err0}, 32'd0);
        chk("rst perr0", {31'd0, perr0}, 32'd0);
        chk("rst busy0", {31'd0, busy0}, 32'd1);
        chk("rst rdata1", rdata1, 32'd0);
        chk("rst rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("rst busy1", {31'd0, busy1}, 32'd1);
        step();
        step();
        reset = 1'b0;
        wait_clear("init");

        // Table: u0 sees vector i after one edge, u1 sees it one edge later
        last0 = '0;
        last1 = '0;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].d, vecs[i].b);
            step();
            chk_port($sformatf("v%0d u0", i), rdata0, rvalid0, err0, perr0, vecs[i], last0);
            if (i > 0)
                chk_port($sformatf("v%0d u1", i - 1), rdata1, rvalid1, err1, perr1, vecs[i - 1], last1);
        end
        drive(1'b0, 1'b0, '0, '0, '0);
        step();
        chk_port($sformatf("v%0d u1", NV - 1), rdata1, rvalid1, err1, perr1, vecs[NV - 1], last1);

        // Reset asserted with a read in flight flushes both pipelines asynchronously
        drive(1'b0, 1'b1, 10'd6, '0, '0);
        step();
        chk("flush pre rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("flush pre rdata0", rdata0, 32'hCAFEF00D);
        drive(1'b0, 1'b0, '0, '0, '0);
        reset = 1'b1;
        #1;
        chk("flush rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("flush rdata0", rdata0, 32'd0);
        chk("flush busy0", {31'd0, busy0}, 32'd1);
        chk("flush rdata1", rdata1, 32'd0);
        step();
        chk("flush rvalid1", {31'd0, rvalid1}, 32'd0);
        reset = 1'b0;

        // Requests during CLEAR are dropped; reset again at clr_cnt=300
        drive(1'b1, 1'b0, 10'd6, 32'hFFFFFFFF, 4'hF);
        for (int c = 0; c < 300; c++) begin
            step();
            if (c == 150) drive(1'b0, 1'b1, 10'd6, '0, '0);
            if (rvalid0 || rvalid1 || !busy0) begin
                chk("clear no response", {29'd0, rvalid0, rvalid1, !busy0}, 32'd0);
            end
        end
        chk("clear busy0", {31'd0, busy0}, 32'd1);
        chk("clear rvalid1", {31'd0, rvalid1}, 32'd0);
        drive(1'b0, 1'b0, '0, '0, '0);
        reset = 1'b1;
        #2 reset = 1'b0;
        wait_clear("restart");

        // Contents are zero after the second clear
        drive(1'b0, 1'b1, 10'd6, '0, '0);
        step();
        drive(1'b0, 1'b0, '0, '0, '0);
        chk("post rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("post rdata0", rdata0, 32'd0);
        step();
        chk("post rvalid1", {31'd0, rvalid1}, 32'd1);
        chk("post rdata1", rdata1, 32'd0);
        chk("post rvalid0 drop", {31'd0, rvalid0}, 32'd0);

`ifdef MEM_PARITY_EN
        u0.pmem[9][0] = ~u0.pmem[9][0];
        drive(1'b0, 1'b1, 10'd9, '0, '0);
        step();
        drive(1'b0, 1'b0, '0, '0, '0);
        chk("parity rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("parity perr0", {31'd0, perr0}, 32'd1);
        step();
        chk("parity perr0 clr", {31'd0, perr0}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
